iob_cache_fe_arbiter: RTL and testbench
=======================================

Name: iob_cache_fe_arbiter

Overview:
Multi-port front-end arbiter that lets N_PORTS native-interface masters share one iob_cache front-end port.
- Captures one request per grant, presents it registered to the cache, and routes ready back to the owning master.
- Selectable round-robin or fixed-priority policy.
- Sits between the CPU/DMA masters and iob_cache (valid/addr/wdata/wstrb/rdata/ready).

Parameters:
N_PORTS, 2, number of master ports (>=1)
FE_ADDR_W, 12, byte-address width of the cache front-end
FE_DATA_W, 32, data word width
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
FE_NBYTES, FE_DATA_W/8, bytes per word (derived, do not override)
FE_BYTE_W, $clog2(FE_NBYTES), byte-offset bits (derived)
PORT_W, (N_PORTS>1)?$clog2(N_PORTS):1, grant index width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
m_valid  in  N_PORTS  per-port request valid
m_addr  in  N_PORTS*(FE_ADDR_W-FE_BYTE_W)  per-port word address; port i occupies slice i
m_wdata  in  N_PORTS*FE_DATA_W  per-port write data
m_wstrb  in  N_PORTS*FE_NBYTES  per-port byte strobes; all-zero means read
m_rdata  out  N_PORTS*FE_DATA_W  per-port read data
m_ready  out  N_PORTS  per-port completion, one-hot or zero
c_valid  out  1  request to cache
c_addr  out  FE_ADDR_W-FE_BYTE_W  cache word address
c_wdata  out  FE_DATA_W  cache write data
c_wstrb  out  FE_NBYTES  cache byte strobes
c_rdata  in  FE_DATA_W  cache read data
c_ready  in  1  cache completion
grant_id  out  PORT_W  index of the currently or last granted port
busy  out  1  transaction outstanding

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock.
- Reset values: c_valid=0, c_addr=0, c_wdata=0, c_wstrb=0, grant_id=0, busy=0, state=IDLE, RR pointer=0. m_ready=0 follows from state=IDLE.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any m_valid=1, select winner g per PRIO_MODE.
  - On the next edge: capture m_addr[g], m_wdata[g], m_wstrb[g] into c_*; set c_valid=1, busy=1, grant_id=g; go to BUSY.
  - Latency: m_valid seen at edge k gives c_valid=1 after edge k+1.
- BUSY:
  - c_* are held stable while c_ready=0.
  - m_ready[grant_id]=c_ready (combinational); all other m_ready bits are 0.
  - On c_ready=1: clear c_valid and busy; go to IDLE. In RR mode, pointer <= grant_id+1 mod N_PORTS.
  - One mandatory idle bubble follows every completion. The completing master's valid in its ready cycle belongs to the finished transaction and is never re-captured.
- c_ready in the first BUSY cycle (zero-wait cache) is legal; the transaction completes in one BUSY cycle.
- c_ready while IDLE is ignored; m_ready stays 0.
- m_rdata is a broadcast of c_rdata to every slice; only m_ready qualifies it.
- Round-robin:
  - Search starts at pointer and wraps at N_PORTS-1 -> 0.
  - With all ports requesting continuously, grants cycle 0,1,..,N-1,0.
  - Worst-case wait is N_PORTS-1 transactions.
- Fixed priority: lowest-index valid wins; the pointer is unused and stays 0.
- A master dropping m_valid mid-transaction (protocol violation) is ignored. The captured request completes and m_ready still pulses.
- Reset asserted mid-transaction: c_valid drops immediately (asynchronously), and the captured request is discarded.
- N_PORTS=1: degenerates to a registered one-slot pass-through with identical timing; grant_id is constant 0.

Decomposition:
- Package iob_cache_arb_pkg holds:
  - policy constants ARB_RR=0 and ARB_FIXED=1
  - state encoding IDLE=1'b0, BUSY=1'b1
  - a function computing PORT_W
- Sub-module iob_cache_rr_prio: a combinational rotating-mask priority encoder.
  - Inputs: req[N_PORTS], ptr[PORT_W], mode.
  - Outputs: gnt_idx[PORT_W], any_req.
- The arbiter top holds the FSM, capture registers and the pointer.

Test Plan:
1. N_PORTS=2, RR: port0 read addr 0x010, cache ready 2 cycles after c_valid, c_rdata=0xDEADBEEF -> c_valid one cycle after m_valid; m_ready=2'b01 for exactly one cycle; m_rdata slice0=0xDEADBEEF; then IDLE.
2. N_PORTS=4, RR: all m_valid held high, masters re-issue after ready, zero-wait cache -> grant_id sequence 0,1,2,3,0,1; one idle cycle between every c_valid pulse.
3. N_PORTS=4, fixed priority: ports 0 and 3 continuously valid -> port 3 never granted over 20 transactions; after port 0 drops valid, port 3 is granted next.
4. Write to addr 0x3F0 with wdata 0xA5A5A5A5 and wstrb 4'b0011, cache stalls 5 cycles while the master changes m_wdata -> c_addr, c_wdata and c_wstrb are held equal to the captured values for the whole stall.
5. Reset driven low in the 2nd BUSY cycle -> c_valid=0, busy=0, grant_id=0 with no clock edge needed; after release, the first request waits the one-cycle capture latency again.
6. c_ready pulsed while IDLE and in the same cycle as c_valid rises -> no m_ready while IDLE; same-cycle ready completes the transaction in one BUSY cycle.

Source files
------------

// File: rtl/iob_cache_arb_pkg.sv
// Shared constants and types for the iob_cache front-end arbiter.
// Imported by the priority encoder and the arbiter top.
package iob_cache_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_cache_rr_prio.sv
// Rotating-mask priority encoder: first requester at or after ptr wins.
// In fixed mode the search always starts at port 0.
module iob_cache_rr_prio
  import iob_cache_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PORT_W  = port_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  input  logic               mode,
  output logic [PORT_W-1:0]  gnt_idx,
  output logic               any_req
);

  int   base;
  int   idx;
  logic found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    base    = mode ? 0 : int'(ptr);
    if (base >= N_PORTS) base = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = base + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = PORT_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/iob_cache_fe_arbiter.sv
// N-port native-interface arbiter in front of one iob_cache port.
// One registered request per grant; ready routed back to the owner.
module iob_cache_fe_arbiter
  import iob_cache_arb_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int FE_ADDR_W = 12,
  parameter int FE_DATA_W = 32,
  parameter int PRIO_MODE = 0,
  parameter int FE_NBYTES = FE_DATA_W / 8,
  parameter int FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int PORT_W    = port_w(N_PORTS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [N_PORTS-1:0]                      m_valid,
  input  logic [N_PORTS*(FE_ADDR_W-FE_BYTE_W)-1:0] m_addr,
  input  logic [N_PORTS*FE_DATA_W-1:0]            m_wdata,
  input  logic [N_PORTS*FE_NBYTES-1:0]            m_wstrb,
  output logic [N_PORTS*FE_DATA_W-1:0]            m_rdata,
  output logic [N_PORTS-1:0]                      m_ready,
  output logic                                    c_valid,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0]          c_addr,
  output logic [FE_DATA_W-1:0]                    c_wdata,
  output logic [FE_NBYTES-1:0]                    c_wstrb,
  input  logic [FE_DATA_W-1:0]                    c_rdata,
  input  logic                                    c_ready,
  output logic [PORT_W-1:0]                       grant_id,
  output logic                                    busy
);

  localparam int ADDR_W = FE_ADDR_W - FE_BYTE_W;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [PORT_W-1:0] ptr;
  logic [PORT_W-1:0] ptr_nxt;
  logic [PORT_W-1:0] gnt;
  logic              any_req;
  logic              fixed_mode;
  logic              capture;
  logic              done;

  assign fixed_mode = (PRIO_MODE == ARB_FIXED);

  iob_cache_rr_prio #(
    .N_PORTS(N_PORTS),
    .PORT_W (PORT_W)
  ) u_prio (
    .req    (m_valid),
    .ptr    (ptr),
    .mode   (fixed_mode),
    .gnt_idx(gnt),
    .any_req(any_req)
  );

  assign capture = (state == IDLE) && any_req;
  assign done    = (state == BUSY) && c_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_ready   = '0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = BUSY;
      end
      BUSY: begin
        m_ready[grant_id] = c_ready;
        if (c_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign c_valid = (state == BUSY);
  assign busy    = (state == BUSY);
  assign m_rdata = {N_PORTS{c_rdata}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_addr   <= '0;
      c_wdata  <= '0;
      c_wstrb  <= '0;
      grant_id <= '0;
    end else if (capture) begin
      c_addr   <= m_addr[int'(gnt)*ADDR_W +: ADDR_W];
      c_wdata  <= m_wdata[int'(gnt)*FE_DATA_W +: FE_DATA_W];
      c_wstrb  <= m_wstrb[int'(gnt)*FE_NBYTES +: FE_NBYTES];
      grant_id <= gnt;
    end
  end

  // Wrap explicitly so non-power-of-two port counts stay in range
  assign ptr_nxt = (int'(grant_id) == N_PORTS - 1) ? '0
                 : grant_id + PORT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   ptr <= '0;
    else if (done && !fixed_mode) ptr <= ptr_nxt;
  end

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Bench for iob_cache_fe_arbiter: 4-port round-robin and fixed-priority
// instances share stimulus and are checked against a transaction model.
module tb_iob_cache_fe_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   m_valid = '0;
  logic [39:0]  m_addr = '0;
  logic [127:0] m_wdata = '0;
  logic [15:0]  m_wstrb = '0;
  logic [31:0]  c_rdata = '0;
  logic         c_ready = 1'b0;

  logic [127:0] rr_m_rdata, fx_m_rdata;
  logic [3:0]   rr_m_ready, fx_m_ready;
  logic         rr_c_valid, fx_c_valid;
  logic [9:0]   rr_c_addr, fx_c_addr;
  logic [31:0]  rr_c_wdata, fx_c_wdata;
  logic [3:0]   rr_c_wstrb, fx_c_wstrb;
  logic [1:0]   rr_grant_id, fx_grant_id;
  logic         rr_busy, fx_busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_cache_fe_arbiter #(
    .N_PORTS(4), .FE_ADDR_W(12), .FE_DATA_W(32), .PRIO_MODE(0)
  ) u_rr (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(rr_m_rdata), .m_ready(rr_m_ready),
    .c_valid(rr_c_valid), .c_addr(rr_c_addr), .c_wdata(rr_c_wdata),
    .c_wstrb(rr_c_wstrb), .c_rdata(c_rdata), .c_ready(c_ready),
    .grant_id(rr_grant_id), .busy(rr_busy)
  );

  iob_cache_fe_arbiter #(
    .N_PORTS(4), .FE_ADDR_W(12), .FE_DATA_W(32), .PRIO_MODE(1)
  ) u_fx (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(fx_m_rdata), .m_ready(fx_m_ready),
    .c_valid(fx_c_valid), .c_addr(fx_c_addr), .c_wdata(fx_c_wdata),
    .c_wstrb(fx_c_wstrb), .c_rdata(c_rdata), .c_ready(c_ready),
    .grant_id(fx_grant_id), .busy(fx_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: index 0 = round-robin, 1 = fixed priority
  bit         mb[2];
  int         mg[2];
  int         mp[2];
  logic [9:0] ma[2];
  logic [31:0] mw[2];
  logic [3:0] ms[2];

  always @(posedge clk or negedge reset) begin
    int w, st, p;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        mb[d] = 1'b0; mg[d] = 0; mp[d] = 0;
        ma[d] = '0; mw[d] = '0; ms[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mb[d]) begin
          if (c_ready) begin
            mb[d] = 1'b0;
            if (d == 0) mp[d] = (mg[d] + 1) % 4;
          end
        end else if (m_valid != 4'b0) begin
          w  = -1;
          st = (d == 0) ? mp[d] : 0;
          for (int k = 0; k < 4; k++) begin
            p = (st + k) % 4;
            if (w < 0 && m_valid[p]) w = p;
          end
          mb[d] = 1'b1;
          mg[d] = w;
          ma[d] = m_addr[w*10 +: 10];
          mw[d] = m_wdata[w*32 +: 32];
          ms[d] = m_wstrb[w*4 +: 4];
        end
      end
    end
  end

  task automatic cmp(input int d, input logic cv, input logic bz,
                     input logic [1:0] gid, input logic [9:0] ca,
                     input logic [31:0] cw, input logic [3:0] cs,
                     input logic [3:0] mr, input logic [127:0] rd);
    string t;
    logic [3:0] er;
    t  = (d == 0) ? "rr" : "fx";
    er = (mb[d] && c_ready) ? (4'b0001 << mg[d]) : 4'b0000;
    chk({t, "_c_valid"}, 64'(cv), 64'(mb[d]));
    chk({t, "_busy"}, 64'(bz), 64'(mb[d]));
    chk({t, "_grant_id"}, 64'(gid), 64'(mg[d]));
    chk({t, "_m_ready"}, 64'(mr), 64'(er));
    if (mb[d]) begin
      chk({t, "_c_addr"}, 64'(ca), 64'(ma[d]));
      chk({t, "_c_wdata"}, 64'(cw), 64'(mw[d]));
      chk({t, "_c_wstrb"}, 64'(cs), 64'(ms[d]));
    end
    if (er != 4'b0)
      for (int s = 0; s < 4; s++)
        chk({t, "_m_rdata"}, 64'(rd[s*32 +: 32]), 64'(c_rdata));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cmp(0, rr_c_valid, rr_busy, rr_grant_id, rr_c_addr, rr_c_wdata,
          rr_c_wstrb, rr_m_ready, rr_m_rdata);
      cmp(1, fx_c_valid, fx_busy, fx_grant_id, fx_c_addr, fx_c_wdata,
          fx_c_wstrb, fx_m_ready, fx_m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  int seq[$];
  int ntr;
  int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    tick();
    at_neg();
    chk("rst_c_valid", 64'(rr_c_valid), 64'd0);
    chk("rst_busy", 64'(rr_busy), 64'd0);
    chk("rst_grant", 64'(rr_grant_id), 64'd0);
    chk("rst_c_addr", 64'(rr_c_addr), 64'd0);
    chk("rst_m_ready", 64'(fx_m_ready), 64'd0);
    tick();
    reset = 1'b1;

    // Read through port 0, cache answers on third BUSY cycle
    tick();
    c_rdata = 32'hDEADBEEF;
    m_valid = 4'b0001;
    m_addr[9:0] = 10'h004;
    at_neg();
    chk("t1_cv_pre", 64'(rr_c_valid), 64'd0);
    tick();
    at_neg();
    chk("t1_cv", 64'(rr_c_valid), 64'd1);
    chk("t1_addr", 64'(rr_c_addr), 64'h004);
    tick();
    at_neg();
    chk("t1_rdy_wait", 64'(rr_m_ready), 64'd0);
    tick();
    c_ready = 1'b1;
    at_neg();
    chk("t1_rdy", 64'(rr_m_ready), 64'b0001);
    chk("t1_rdata", 64'(rr_m_rdata[31:0]), 64'hDEADBEEF);
    tick();
    c_ready = 1'b0;
    m_valid = 4'b0000;
    at_neg();
    chk("t1_idle", 64'(rr_busy), 64'd0);
    chk("t1_rdy_off", 64'(rr_m_ready), 64'd0);

    // All ports requesting, zero-wait cache
    do_reset();
    m_valid = 4'b1111;
    c_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      at_neg();
      chk("t2_bubble", 64'(rr_c_valid), 64'(i % 2));
      if (rr_c_valid) seq.push_back(int'(rr_grant_id));
      tick();
    end
    m_valid = 4'b0000;
    c_ready = 1'b0;
    chk("t2_count", 64'(seq.size()), 64'd6);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk("t2_seq", 64'(seq[i]), 64'(exp_seq[i]));

    // Fixed priority: port 3 starved while port 0 requests
    do_reset();
    m_valid = 4'b1001;
    c_ready = 1'b1;
    ntr = 0;
    for (int i = 0; i < 40; i++) begin
      at_neg();
      if (fx_c_valid) begin
        ntr++;
        chk("t3_fx_grant", 64'(fx_grant_id), 64'd0);
      end
      tick();
    end
    chk("t3_ntr", 64'(ntr), 64'd20);
    m_valid = 4'b1000;
    at_neg();
    tick();
    at_neg();
    chk("t3_p3_cv", 64'(fx_c_valid), 64'd1);
    chk("t3_p3_grant", 64'(fx_grant_id), 64'd3);
    tick();
    m_valid = 4'b0000;
    c_ready = 1'b0;

    // Write from port 1 held across a 5-cycle stall
    m_valid = 4'b0010;
    m_addr[19:10] = 10'h0FC;
    m_wdata[63:32] = 32'hA5A5A5A5;
    m_wstrb[7:4] = 4'b0011;
    tick();
    for (int i = 0; i < 5; i++) begin
      m_wdata[63:32] = 32'h11111111 * (i + 1);
      at_neg();
      chk("t4_addr", 64'(rr_c_addr), 64'h0FC);
      chk("t4_wdata", 64'(rr_c_wdata), 64'hA5A5A5A5);
      chk("t4_wstrb", 64'(rr_c_wstrb), 64'b0011);
      tick();
    end
    c_ready = 1'b1;
    at_neg();
    chk("t4_rdy", 64'(rr_m_ready), 64'b0010);
    tick();
    c_ready = 1'b0;
    m_valid = 4'b0000;

    // Asynchronous reset in the second BUSY cycle
    do_reset();
    m_valid = 4'b0100;
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    chk("t5_cv", 64'(rr_c_valid), 64'd0);
    chk("t5_busy", 64'(rr_busy), 64'd0);
    chk("t5_grant", 64'(rr_grant_id), 64'd0);
    chk("t5_fx_cv", 64'(fx_c_valid), 64'd0);
    tick();
    reset = 1'b1;
    at_neg();
    chk("t5_cv_lat", 64'(rr_c_valid), 64'd0);
    tick();
    at_neg();
    chk("t5_cv_cap", 64'(rr_c_valid), 64'd1);
    chk("t5_grant2", 64'(rr_grant_id), 64'd2);
    tick();
    c_ready = 1'b1;
    at_neg();
    chk("t5_rdy", 64'(rr_m_ready), 64'b0100);
    tick();
    c_ready = 1'b0;
    m_valid = 4'b0000;

    // Ready while idle, then ready in the first BUSY cycle
    tick();
    c_ready = 1'b1;
    at_neg();
    chk("t6_idle_rdy", 64'(rr_m_ready), 64'd0);
    chk("t6_idle_busy", 64'(rr_busy), 64'd0);
    tick();
    m_valid = 4'b0001;
    at_neg();
    chk("t6_pre_rdy", 64'(rr_m_ready), 64'd0);
    tick();
    at_neg();
    chk("t6_cv", 64'(rr_c_valid), 64'd1);
    chk("t6_rdy", 64'(rr_m_ready), 64'b0001);
    tick();
    m_valid = 4'b0000;
    c_ready = 1'b0;
    at_neg();
    chk("t6_done", 64'(rr_c_valid), 64'd0);
    chk("t6_done_busy", 64'(fx_busy), 64'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
